// File: rtl/arith_encoder_frame_ctrl.sv
// Frame sequencer in front of the arithmetic encoder: feeds beats, drains the
// pipeline on the last symbol, captures final RANGE/LOW and resets the encoder.
module arith_encoder_frame_ctrl #(
    parameter int RANGE_WIDTH     = 16,
    parameter int LOW_WIDTH       = 24,
    parameter int SYMBOL_WIDTH    = 4,
    parameter int PIPELINE_STAGES = 3,
    parameter int FRAME_CNT_WIDTH = 16,
    parameter int SYM_CNT_WIDTH   = 20
) (
    input  logic                       general_clk,
    input  logic                       reset,
    input  logic                       sym_valid,
    output logic                       sym_ready,
    input  logic [RANGE_WIDTH-1:0]     sym_fl,
    input  logic [RANGE_WIDTH-1:0]     sym_fh,
    input  logic [SYMBOL_WIDTH-1:0]    sym_symbol,
    input  logic [SYMBOL_WIDTH:0]      sym_nsyms,
    input  logic                       sym_bool,
    input  logic                       sym_last,
    output logic                       enc_reset,
    output logic                       enc_valid,
    output logic [RANGE_WIDTH-1:0]     enc_fl,
    output logic [RANGE_WIDTH-1:0]     enc_fh,
    output logic [SYMBOL_WIDTH-1:0]    enc_symbol,
    output logic [SYMBOL_WIDTH:0]      enc_nsyms,
    output logic                       enc_bool,
    input  logic [RANGE_WIDTH-1:0]     enc_range,
    input  logic [LOW_WIDTH-1:0]       enc_low,
    output logic                       frame_done,
    output logic [RANGE_WIDTH-1:0]     frame_range,
    output logic [LOW_WIDTH-1:0]       frame_low,
    output logic [SYM_CNT_WIDTH-1:0]   frame_symbols,
    output logic [FRAME_CNT_WIDTH-1:0] frame_count
);

    localparam int DW = $clog2(PIPELINE_STAGES + 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_RUN,
        S_DRAIN,
        S_CAPTURE,
        S_FRESET
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [DW-1:0]            drain_cnt;
    logic [SYM_CNT_WIDTH-1:0] sym_cnt;
    logic                     accept;

    // Ready is masked by reset so a beat is never seen as taken in a reset cycle.
    assign sym_ready  = (state == S_RUN) && !reset;
    assign accept     = sym_valid && sym_ready;
    assign enc_reset  = reset || (state == S_INIT) || (state == S_FRESET);
    assign frame_done = (state == S_FRESET);

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_INIT:    state_nxt = S_RUN;
            S_RUN:     if (accept && sym_last) state_nxt = S_DRAIN;
            S_DRAIN:   if (drain_cnt <= DW'(1)) state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_FRESET;
            S_FRESET:  state_nxt = S_RUN;
            default:   state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge general_clk) begin
        if (reset) begin
            state         <= S_INIT;
            drain_cnt     <= '0;
            sym_cnt       <= '0;
            enc_valid     <= 1'b0;
            enc_fl        <= '0;
            enc_fh        <= '0;
            enc_symbol    <= '0;
            enc_nsyms     <= '0;
            enc_bool      <= 1'b0;
            frame_range   <= '0;
            frame_low     <= '0;
            frame_symbols <= '0;
            frame_count   <= '0;
        end else begin
            state     <= state_nxt;
            enc_valid <= accept;
            if (accept) begin
                enc_fl     <= sym_fl;
                enc_fh     <= sym_fh;
                enc_symbol <= sym_symbol;
                enc_nsyms  <= sym_nsyms;
                enc_bool   <= sym_bool;
                if (sym_cnt != '1) sym_cnt <= sym_cnt + 1'b1;
            end
            // Counts the cycles until the last symbol's result reaches enc_range/low.
            if (accept && sym_last) begin
                drain_cnt <= DW'(PIPELINE_STAGES);
            end else if (state == S_DRAIN) begin
                drain_cnt <= drain_cnt - 1'b1;
            end
            if (state == S_CAPTURE) begin
                frame_range   <= enc_range;
                frame_low     <= enc_low;
                frame_symbols <= sym_cnt;
                frame_count   <= frame_count + 1'b1;
            end
            if (state == S_FRESET) sym_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_arith_encoder_frame_ctrl.sv
// Bench for arith_encoder_frame_ctrl: a behavioural pipelined encoder plant,
// table-driven frames, reset-in-drain corner case and random frames.
module tb_arith_encoder_frame_ctrl;

    localparam int RW  = 16;
    localparam int LW  = 24;
    localparam int SW  = 4;
    localparam int P   = 3;
    localparam int FCW = 16;
    localparam int SCW = 20;

    logic           general_clk = 1'b0;
    logic           reset = 1'b1;
    logic           sym_valid, sym_ready;
    logic [RW-1:0]  sym_fl, sym_fh;
    logic [SW-1:0]  sym_symbol;
    logic [SW:0]    sym_nsyms;
    logic           sym_bool, sym_last;
    logic           enc_reset, enc_valid;
    logic [RW-1:0]  enc_fl, enc_fh;
    logic [SW-1:0]  enc_symbol;
    logic [SW:0]    enc_nsyms;
    logic           enc_bool;
    logic [RW-1:0]  enc_range;
    logic [LW-1:0]  enc_low;
    logic           frame_done;
    logic [RW-1:0]  frame_range;
    logic [LW-1:0]  frame_low;
    logic [SCW-1:0] frame_symbols;
    logic [FCW-1:0] frame_count;

    always #5 general_clk = ~general_clk;

    arith_encoder_frame_ctrl #(
        .RANGE_WIDTH(RW), .LOW_WIDTH(LW), .SYMBOL_WIDTH(SW),
        .PIPELINE_STAGES(P), .FRAME_CNT_WIDTH(FCW), .SYM_CNT_WIDTH(SCW)
    ) dut (
        .general_clk(general_clk), .reset(reset),
        .sym_valid(sym_valid), .sym_ready(sym_ready),
        .sym_fl(sym_fl), .sym_fh(sym_fh), .sym_symbol(sym_symbol),
        .sym_nsyms(sym_nsyms), .sym_bool(sym_bool), .sym_last(sym_last),
        .enc_reset(enc_reset), .enc_valid(enc_valid),
        .enc_fl(enc_fl), .enc_fh(enc_fh), .enc_symbol(enc_symbol),
        .enc_nsyms(enc_nsyms), .enc_bool(enc_bool),
        .enc_range(enc_range), .enc_low(enc_low),
        .frame_done(frame_done), .frame_range(frame_range),
        .frame_low(frame_low), .frame_symbols(frame_symbols),
        .frame_count(frame_count)
    );

    typedef struct packed {
        logic [RW-1:0] fl;
        logic [RW-1:0] fh;
        logic [SW-1:0] sym;
        logic [SW:0]   ns;
        logic          b;
    } beat_t;

    typedef struct {
        int n;
        int mode;
        bit fixed;
        bit reuse;
        int e_syms;
        int e_ev;
        int e_rises;
    } vec_t;

    int    checks = 0;
    int    errors = 0;
    int    exp_frames = 0;
    beat_t beats [16];
    beat_t exp_q [$];
    beat_t cur;
    vec_t  vecs [3];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Toy encoder step: any deterministic mixing of state and beat will do.
    function automatic logic [RW+LW-1:0] step(input logic [RW-1:0] r,
                                              input logic [LW-1:0] l,
                                              input beat_t x);
        logic [RW-1:0] r2;
        logic [LW-1:0] l2;
        r2 = (r ^ x.fl) + x.fh + RW'({x.sym, x.ns, x.b});
        l2 = (l * LW'(3)) + LW'(r) + LW'(x.fl);
        return {r2, l2};
    endfunction

    function automatic logic [RW+LW-1:0] model(input int n);
        logic [RW+LW-1:0] s;
        s = {16'h8000, 24'h0};
        for (int i = 0; i < n; i++) s = step(s[RW+LW-1:LW], s[LW-1:0], beats[i]);
        return s;
    endfunction

    // Encoder plant: input in cycle T, result on enc_range/enc_low in T+P.
    logic [RW-1:0] pr [P];
    logic [LW-1:0] pl [P];
    assign cur       = {enc_fl, enc_fh, enc_symbol, enc_nsyms, enc_bool};
    assign enc_range = pr[P-1];
    assign enc_low   = pl[P-1];

    always @(posedge general_clk) begin : plant
        logic [RW+LW-1:0] s;
        if (enc_reset) begin
            for (int i = 0; i < P; i++) begin
                pr[i] <= 16'h8000;
                pl[i] <= '0;
            end
        end else begin
            s = enc_valid ? step(pr[0], pl[0], cur) : {pr[0], pl[0]};
            pr[0] <= s[RW+LW-1:LW];
            pl[0] <= s[LW-1:0];
            for (int i = 1; i < P; i++) begin
                pr[i] <= pr[i-1];
                pl[i] <= pl[i-1];
            end
        end
    end

    int    ev_cnt = 0, ev_rises = 0, lowrun = 0, last_lowrun = 0, done_cnt = 0;
    logic  prev_ev = 1'b0;
    beat_t mon_e;

    always @(negedge general_clk) begin
        if (enc_valid === 1'b1) begin
            ev_cnt++;
            if (!prev_ev) ev_rises++;
            if (exp_q.size() == 0) begin
                chk("enc_unexpected_valid", 64'(1), 64'(0));
            end else begin
                mon_e = exp_q.pop_front();
                chk("enc_data", 64'(cur), 64'(mon_e));
            end
        end
        prev_ev = (enc_valid === 1'b1);
        if (sym_ready !== 1'b1) begin
            lowrun++;
        end else begin
            if (lowrun > 0) last_lowrun = lowrun;
            lowrun = 0;
        end
        if (frame_done === 1'b1) done_cnt++;
    end

    task automatic fill(input int n);
        for (int i = 0; i < n; i++)
            beats[i] = {16'($urandom), 16'($urandom), 4'($urandom),
                        5'($urandom), 1'($urandom)};
    endtask

    task automatic idle(input int k);
        sym_valid = 1'b0;
        repeat (k) @(posedge general_clk);
        #1;
    endtask

    task automatic send(input beat_t b, input bit last);
        int g;
        sym_valid = 1'b1;
        {sym_fl, sym_fh, sym_symbol, sym_nsyms, sym_bool} = b;
        sym_last = last;
        g = 0;
        @(negedge general_clk);
        while (sym_ready !== 1'b1 && g < 50) begin
            g++;
            @(negedge general_clk);
        end
        if (g >= 50) chk("accept_timeout", 64'(0), 64'(1));
        else exp_q.push_back(b);
        @(posedge general_clk);
        #1;
        sym_valid = 1'b0;
        sym_last  = 1'b0;
    endtask

    task automatic run_frame(input int n, input int mode, input int e_syms,
                             input int e_ev, input int e_rises);
        logic [RW+LW-1:0] m;
        bit seen;
        int lat;
        ev_cnt = 0;
        ev_rises = 0;
        for (int i = 0; i < n; i++) begin
            if (mode == 1 && i > 0) idle(1);
            if (mode == 2) idle($urandom_range(0, 2));
            send(beats[i], i == n - 1);
        end
        m = model(n);
        exp_frames++;
        seen = 0;
        lat = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge general_clk);
            if (frame_done === 1'b1) begin
                seen = 1;
                lat = k;
            end
        end
        chk("frame_done_seen", 64'(seen), 64'(1));
        chk("frame_done_latency", 64'(lat), 64'(P + 2));
        chk("frame_range", 64'(frame_range), 64'(m[RW+LW-1:LW]));
        chk("frame_low", 64'(frame_low), 64'(m[LW-1:0]));
        chk("frame_symbols", 64'(frame_symbols), 64'(e_syms));
        chk("frame_count", 64'(frame_count), 64'(FCW'(exp_frames)));
        @(negedge general_clk);
        chk("frame_done_pulse", 64'(frame_done), 64'(0));
        chk("ready_after_frame", 64'(sym_ready), 64'(1));
        @(negedge general_clk);
        chk("ready_low_cycles", 64'(last_lowrun), 64'(P + 2));
        chk("enc_valid_cycles", 64'(ev_cnt), 64'(e_ev));
        if (e_rises >= 0) chk("enc_valid_bursts", 64'(ev_rises), 64'(e_rises));
        chk("enc_queue_empty", 64'(exp_q.size()), 64'(0));
        @(posedge general_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{n: 1,  mode: 0, fixed: 1, reuse: 0, e_syms: 1,  e_ev: 1,  e_rises: 1};
        vecs[1] = '{n: 10, mode: 0, fixed: 0, reuse: 0, e_syms: 10, e_ev: 10, e_rises: 1};
        vecs[2] = '{n: 10, mode: 1, fixed: 0, reuse: 1, e_syms: 10, e_ev: 10, e_rises: 10};
        sym_valid = 0;
        sym_last = 0;
        {sym_fl, sym_fh, sym_symbol, sym_nsyms, sym_bool} = '0;

        // Reset held two cycles, then INIT for one cycle
        @(posedge general_clk);
        @(negedge general_clk);
        chk("rst_enc_reset", 64'(enc_reset), 64'(1));
        chk("rst_sym_ready", 64'(sym_ready), 64'(0));
        chk("rst_enc_valid", 64'(enc_valid), 64'(0));
        chk("rst_enc_data", 64'(cur), 64'(0));
        chk("rst_frame_done", 64'(frame_done), 64'(0));
        chk("rst_frame_count", 64'(frame_count), 64'(0));
        chk("rst_frame_data", 64'({frame_range, frame_low}), 64'(0));
        chk("rst_frame_symbols", 64'(frame_symbols), 64'(0));
        @(posedge general_clk);
        #1 reset = 1'b0;
        @(negedge general_clk);
        chk("init_enc_reset", 64'(enc_reset), 64'(1));
        chk("init_sym_ready", 64'(sym_ready), 64'(0));
        @(negedge general_clk);
        chk("run_sym_ready", 64'(sym_ready), 64'(1));
        chk("run_enc_reset", 64'(enc_reset), 64'(0));
        @(posedge general_clk);
        #1;

        for (int t = 0; t < 3; t++) begin
            if (!vecs[t].reuse) fill(vecs[t].n);
            if (vecs[t].fixed)
                beats[0] = '{fl: 16'h8000, fh: 16'h4000, sym: 4'd1, ns: 5'd2, b: 1'b0};
            run_frame(vecs[t].n, vecs[t].mode, vecs[t].e_syms,
                      vecs[t].e_ev, vecs[t].e_rises);
        end

        // Reset during DRAIN cycle T+1 discards the frame
        fill(4);
        for (int i = 0; i < 4; i++) send(beats[i], i == 3);
        done_cnt = 0;
        @(negedge general_clk);
        @(negedge general_clk);
        reset = 1'b1;
        @(posedge general_clk);
        @(negedge general_clk);
        chk("drain_rst_enc_reset", 64'(enc_reset), 64'(1));
        chk("drain_rst_sym_ready", 64'(sym_ready), 64'(0));
        @(posedge general_clk);
        #1 reset = 1'b0;
        @(negedge general_clk);
        chk("drain_rst_init_enc_reset", 64'(enc_reset), 64'(1));
        chk("drain_rst_init_ready", 64'(sym_ready), 64'(0));
        chk("drain_rst_count", 64'(frame_count), 64'(0));
        @(negedge general_clk);
        chk("drain_rst_ready_back", 64'(sym_ready), 64'(1));
        repeat (8) @(negedge general_clk);
        chk("drain_rst_no_done", 64'(done_cnt), 64'(0));
        chk("drain_rst_count_hold", 64'(frame_count), 64'(0));
        chk("drain_rst_queue", 64'(exp_q.size()), 64'(0));
        exp_frames = 0;
        @(posedge general_clk);
        #1;
        fill(3);
        run_frame(3, 0, 3, 3, 1);

        // Random frames with random bubbles
        for (int f = 0; f < 12; f++) begin
            int n;
            n = $urandom_range(1, 12);
            fill(n);
            run_frame(n, 2, n, n, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
